// File: rtl/instr_cache_refill_ctrl_if.sv
// Memory-side read channel of the instruction cache refill engine:
// one request/accept handshake followed by a stream of 64-bit read beats.
interface instr_cache_refill_ctrl_if #(
  parameter int AddrWidth = 32
);
  logic                 MemReq;
  logic [AddrWidth-1:0] MemAddr;
  logic                 MemReqReady;
  logic                 MemRValid;
  logic [63:0]          MemRData;

  modport master (
    output MemReq,
    output MemAddr,
    input  MemReqReady,
    input  MemRValid,
    input  MemRData
  );

  modport slave (
    input  MemReq,
    input  MemAddr,
    output MemReqReady,
    output MemRValid,
    output MemRData
  );
endinterface

// File: rtl/instr_cache_refill_ctrl.sv
// Instruction cache refill engine: turns a set miss into one line-fill read,
// streams the returned beats into the set and stalls fetch until the line is in.
module instr_cache_refill_ctrl #(
  parameter int B         = 64,
  parameter int AddrWidth = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [AddrWidth-1:0]    PCF,
  input  logic                    CacheMiss,
  input  logic                    Flush,
  instr_cache_refill_ctrl_if.master mem,
  output logic                    RepEnable,
  output logic [63:0]             RepWord,
  output logic                    RefillDone,
  output logic                    StallF
);
  localparam int                   Beats    = B / 8;
  localparam int                   CntW     = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntW-1:0]      LastBeat = CntW'(Beats - 1);
  localparam logic [AddrWidth-1:0] OffMask  = AddrWidth'(B - 1);

  typedef enum logic [2:0] {IDLE, REQ, FILL, DRAIN, DONE} state_t;

  state_t          state;
  logic [CntW-1:0] beatCnt;
  logic            missTake;
  logic            lastIn;

  always_comb begin
    missTake = (state == IDLE) && CacheMiss && !Flush;
    lastIn   = mem.MemRValid && (beatCnt == LastBeat);
    StallF   = missTake || (state == REQ) || (state == FILL) || (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      beatCnt     <= '0;
      mem.MemReq  <= 1'b0;
      mem.MemAddr <= '0;
      RepEnable   <= 1'b0;
      RepWord     <= '0;
      RefillDone  <= 1'b0;
    end else begin
      RepEnable  <= 1'b0;
      RefillDone <= 1'b0;
      case (state)
        IDLE: begin
          beatCnt <= '0;
          if (missTake) begin
            mem.MemAddr <= PCF & ~OffMask;
            mem.MemReq  <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          // Acceptance wins over a concurrent Flush: the read is already owed,
          // so its beats must still be drained.
          if (mem.MemReqReady) begin
            mem.MemReq <= 1'b0;
            beatCnt    <= '0;
            state      <= Flush ? DRAIN : FILL;
          end else if (Flush) begin
            mem.MemReq <= 1'b0;
            state      <= IDLE;
          end
        end
        FILL: begin
          if (mem.MemRValid) begin
            if (!Flush) begin
              RepEnable <= 1'b1;
              RepWord   <= mem.MemRData;
            end
            if (lastIn) begin
              beatCnt    <= '0;
              RefillDone <= !Flush;
              state      <= Flush ? IDLE : DONE;
            end else begin
              beatCnt <= beatCnt + 1'b1;
              if (Flush) state <= DRAIN;
            end
          end else if (Flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem.MemRValid) begin
            if (lastIn) begin
              beatCnt <= '0;
              state   <= IDLE;
            end else begin
              beatCnt <= beatCnt + 1'b1;
            end
          end
        end
        DONE: begin
          // The set only reports the hit next cycle, so CacheMiss is not sampled here.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_cache_refill_ctrl.sv
// Directed bench for instr_cache_refill_ctrl: forwarded beats go into a
// scoreboard queue and are matched against RepWord whenever RepEnable fires.
module tb_instr_cache_refill_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        CacheMiss;
  logic        Flush;
  logic        RepEnable;
  logic [63:0] RepWord;
  logic        RefillDone;
  logic        StallF;

  instr_cache_refill_ctrl_if #(.AddrWidth(32)) memBus ();

  instr_cache_refill_ctrl #(.B(64), .AddrWidth(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .PCF        (PCF),
    .CacheMiss  (CacheMiss),
    .Flush      (Flush),
    .mem        (memBus),
    .RepEnable  (RepEnable),
    .RepWord    (RepWord),
    .RefillDone (RefillDone),
    .StallF     (StallF)
  );

  always #5 clk = ~clk;

  int          nAsserts  = 0;
  int          nFail     = 0;
  int          repCount  = 0;
  int          doneCount = 0;
  logic [63:0] q[$];
  logic [63:0] lastWord  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every RepEnable must match the oldest forwarded beat.
  always @(negedge clk) begin
    if (!reset) begin
      if (RepEnable) begin
        repCount++;
        if (q.size() == 0) chkb("RepEnableUnexpected", RepEnable, 1'b0);
        else               chk("RepWord", RepWord, q.pop_front());
      end
      if (RefillDone) begin
        doneCount++;
        chkb("DoneWithRep", RepEnable, 1'b1);
      end
    end
  end

  task automatic checkZero(input string tag);
    chkb({tag, "_MemReq"}, memBus.MemReq, 1'b0);
    chk({tag, "_MemAddr"}, 64'(memBus.MemAddr), 64'h0);
    chkb({tag, "_RepEnable"}, RepEnable, 1'b0);
    chk({tag, "_RepWord"}, RepWord, 64'h0);
    chkb({tag, "_RefillDone"}, RefillDone, 1'b0);
    chkb({tag, "_StallF"}, StallF, 1'b0);
  endtask

  task automatic beat(input logic v, input logic [63:0] d, input logic fwd);
    memBus.MemRValid = v;
    memBus.MemRData  = d;
    if (v && fwd) q.push_back(d);
    @(negedge clk);
    chkb("RepEnableLag", RepEnable, v && fwd);
    if (fwd && !v) chk("RepWordHeld", RepWord, lastWord);
    if (v && fwd) lastWord = d;
  endtask

  // Cycles through pat (LSB first) until a full line of valid beats is sent.
  task automatic fillBeats(input logic [63:0] base, input logic [15:0] pat);
    int n = 0;
    for (int c = 0; c < 64 && n < 8; c++) begin
      beat(pat[c % 16], base + 64'(n), 1'b1);
      if (pat[c % 16]) n++;
    end
    chk("BeatBudget", 64'(n), 64'd8);
  endtask

  task automatic startMiss(input logic [31:0] addr, input logic [31:0] expAddr);
    PCF       = addr;
    CacheMiss = 1'b1;
    Flush     = 1'b0;
    @(negedge clk);
    chkb("MemReqIssued", memBus.MemReq, 1'b1);
    chk("MemAddr", 64'(memBus.MemAddr), 64'(expAddr));
    CacheMiss = 1'b0;
  endtask

  task automatic finishRefill();
    chkb("RefillDone", RefillDone, 1'b1);
    chkb("StallInDone", StallF, 1'b1);
    memBus.MemRValid = 1'b0;
    @(negedge clk);
    chkb("RefillDonePulse", RefillDone, 1'b0);
    chkb("StallAfterDone", StallF, 1'b0);
    chkb("RepEnableAfterDone", RepEnable, 1'b0);
  endtask

  task automatic checkCounts(input int expRep, input int expDone);
    #1;
    chk("RepCount", 64'(repCount), 64'(expRep));
    chk("DoneCount", 64'(doneCount), 64'(expDone));
    chk("QueueEmpty", 64'(q.size()), 64'd0);
    repCount  = 0;
    doneCount = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; PCF = '0; CacheMiss = 1'b0; Flush = 1'b0;
    memBus.MemReqReady = 1'b0; memBus.MemRValid = 1'b0; memBus.MemRData = '0;
    repeat (2) @(negedge clk);
    checkZero("reset");
    reset = 1'b0;

    // Back-to-back beats, zero latency
    memBus.MemReqReady = 1'b1;
    PCF = 32'h0000_1234; CacheMiss = 1'b1;
    #1 chkb("StallMissIdle", StallF, 1'b1);
    @(negedge clk);
    chkb("MemReq", memBus.MemReq, 1'b1);
    chk("MemAddr", 64'(memBus.MemAddr), 64'h1200);
    chkb("NoRepInReq", RepEnable, 1'b0);
    CacheMiss = 1'b0;
    @(negedge clk);
    chkb("MemReqDropped", memBus.MemReq, 1'b0);
    chkb("StallFill", StallF, 1'b1);
    fillBeats(64'h1111_0000_0000_0000, 16'hFFFF);
    finishRefill();
    checkCounts(8, 1);

    // Miss with Flush ignored; Flush before acceptance drops the request
    PCF = 32'h0000_2234; CacheMiss = 1'b1; Flush = 1'b1; memBus.MemReqReady = 1'b0;
    #1 chkb("StallFlushIdle", StallF, 1'b0);
    @(negedge clk);
    chkb("NoReqOnFlush", memBus.MemReq, 1'b0);
    startMiss(32'h0000_2234, 32'h0000_2200);
    Flush = 1'b1;
    @(negedge clk);
    chkb("ReqDroppedFlush", memBus.MemReq, 1'b0);
    chkb("StallAfterReqFlush", StallF, 1'b0);
    Flush = 1'b0;

    // Request held while memory is not ready
    startMiss(32'h0000_1234, 32'h0000_1200);
    PCF = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chkb("MemReqHeld", memBus.MemReq, 1'b1);
      chk("MemAddrHeld", 64'(memBus.MemAddr), 64'h1200);
      chkb("NoRepWhileWaiting", RepEnable, 1'b0);
    end
    memBus.MemReqReady = 1'b1;
    @(negedge clk);
    chkb("MemReqAccepted", memBus.MemReq, 1'b0);
    fillBeats(64'h2222_0000_0000_0000, 16'hFFFF);
    finishRefill();
    checkCounts(8, 1);

    // Beats with gaps: 1,0,0,1,1,0,1,1,0,1,1,1
    startMiss(32'h0000_3000, 32'h0000_3000);
    @(negedge clk);
    fillBeats(64'h3333_0000_0000_0000, 16'h0ED9);
    finishRefill();
    checkCounts(8, 1);

    // Flush after three beats: rest is drained silently
    startMiss(32'h0000_4010, 32'h0000_4000);
    @(negedge clk);
    for (int i = 0; i < 3; i++) beat(1'b1, 64'h4444_0000_0000_0000 + 64'(i), 1'b1);
    Flush = 1'b1;
    beat(1'b1, 64'h4444_0000_0000_0003, 1'b0);
    chkb("StallDrainStart", StallF, 1'b0);
    Flush = 1'b0;
    for (int i = 4; i < 8; i++) begin
      beat(1'b1, 64'h4444_0000_0000_0000 + 64'(i), 1'b0);
      chkb("StallDrain", StallF, 1'b0);
      chkb("NoDoneDrain", RefillDone, 1'b0);
    end
    memBus.MemRValid = 1'b0;
    checkCounts(3, 0);
    startMiss(32'h0000_5040, 32'h0000_5040);
    @(negedge clk);
    fillBeats(64'h5555_0000_0000_0000, 16'hFFFF);
    finishRefill();
    checkCounts(8, 1);

    // Reset mid-fill, trailing beats ignored
    startMiss(32'h0000_6000, 32'h0000_6000);
    @(negedge clk);
    for (int i = 0; i < 5; i++) beat(1'b1, 64'h6666_0000_0000_0000 + 64'(i), 1'b1);
    #1;
    reset = 1'b1;
    memBus.MemRValid = 1'b1;
    memBus.MemRData  = 64'h6666_0000_0000_0005;
    #1 checkZero("midFillReset");
    lastWord = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 6; i < 9; i++) begin
      beat(1'b1, 64'h6666_0000_0000_0000 + 64'(i), 1'b0);
      chkb("NoReqAfterReset", memBus.MemReq, 1'b0);
    end
    memBus.MemRValid = 1'b0;
    checkCounts(5, 0);

    // Sequential misses at 0x40 and 0x80
    startMiss(32'h0000_0040, 32'h0000_0040);
    @(negedge clk);
    fillBeats(64'h7777_0000_0000_0000, 16'hFFFF);
    chkb("RefillDoneFirst", RefillDone, 1'b1);
    PCF = 32'h0000_0080; CacheMiss = 1'b1; memBus.MemRValid = 1'b0;
    #1 chkb("StallDoneWithMiss", StallF, 1'b1);
    @(negedge clk);
    chkb("NoReqFromDone", memBus.MemReq, 1'b0);
    chkb("RefillDoneCleared", RefillDone, 1'b0);
    chkb("StallIdleMiss", StallF, 1'b1);
    @(negedge clk);
    chkb("SecondMemReq", memBus.MemReq, 1'b1);
    chk("SecondMemAddr", 64'(memBus.MemAddr), 64'h80);
    CacheMiss = 1'b0;
    @(negedge clk);
    fillBeats(64'h8888_0000_0000_0000, 16'hFFFF);
    finishRefill();
    checkCounts(16, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end
endmodule
